mac_frame_accumulator: RTL and testbench
========================================

Name: mac_frame_accumulator

Overview:
- Downstream consumer of the registered multiply-accumulate stage (result = A*B + C).
- Collects a frame of ACC_LEN consecutive products, sums them without overflow, and presents the frame sum on a valid/ready output.
- Sits between the MAC register and the result readout/statistics logic.
- Supports early frame termination (flush) with a reported sample count.

Parameters:
- IN_WIDTH, default params::DATA_OUT_WIDTH: width of the incoming MAC result, unsigned.
- ACC_LEN, default 8: samples per full frame, legal range 2..256.
- CNT_WIDTH, derived $clog2(ACC_LEN+1): width of the sample counter and count_out.
- SUM_WIDTH, derived IN_WIDTH+$clog2(ACC_LEN): accumulator width, guarantees no overflow.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  IN_WIDTH  MAC result sample, unsigned.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- flush  input  1  terminate the current frame early.
- out_sum  output  SUM_WIDTH  frame sum.
- out_count  output  CNT_WIDTH  number of samples in the frame, 1..ACC_LEN.
- out_valid  output  1  out_sum and out_count are valid.
- out_ready  input  1  downstream accepts the output.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is reset_n, asynchronous, active-low.
  - Reset values: out_sum=0, out_count=0, out_valid=0, accumulator=0, counter=0, state=ACCUM.
  - in_ready is 1 immediately on reset.
- A sample is accepted when in_valid && in_ready are both high on the same edge.
- The FSM has two states, ACCUM and HOLD.
- ACCUM state:
  - in_ready=1, out_valid=0.
  - On accept when counter < ACC_LEN-1 and flush is low: accumulator += in_data, counter += 1.
  - On accept when counter == ACC_LEN-1: out_sum <= accumulator + in_data, out_count <= ACC_LEN, accumulator <= 0, counter <= 0, out_valid <= 1, go to HOLD.
  - flush with accept in the same cycle: the sample is included, the partial frame is emitted with out_count = counter+1, then go to HOLD.
  - flush without accept and counter > 0: emit out_sum = accumulator, out_count = counter, clear accumulator and counter, go to HOLD.
  - flush without accept and counter == 0: ignored, no empty frames are ever emitted.
- HOLD state:
  - in_ready=0, out_valid=1.
  - out_sum and out_count are held stable.
  - in_valid and flush are ignored.
  - When out_ready is high: out_valid <= 0, go to ACCUM.
  - The earliest next sample is accepted on the edge after the handshake.
- Latency:
  - The last accepted sample (or a flush) at edge n gives out_valid=1 after edge n.
  - Minimum frame period is ACC_LEN+1 cycles; one bubble per frame.
- Arithmetic:
  - Unsigned, zero-extended to SUM_WIDTH.
  - No wrap is possible because SUM_WIDTH is sized for ACC_LEN × max(in_data).
- Reset mid-frame or mid-HOLD: the partial frame and any pending output are discarded, and all registers return to reset values.
- out_ready high while in ACCUM: no effect.

Optional Feature:
- Macro: MAC_FRAME_ACC_AVG_EN.
- Defined:
  - Adds output port out_avg, IN_WIDTH wide, equal to out_sum >> $clog2(ACC_LEN).
  - out_avg is registered together with out_sum, with the same valid, hold and reset behaviour (reset 0).
  - ACC_LEN must be a power of two; otherwise elaboration fails via $error.
  - Partial (flushed) frames are still divided by ACC_LEN, not by out_count.
- Undefined: no out_avg port, no divider logic, and ACC_LEN is any legal value.

Test Plan:
- Reset with ACC_LEN=4, IN_WIDTH=16 -> out_valid=0, out_sum=0, out_count=0, in_ready=1 while reset_n=0 and immediately after release.
- Samples 10,20,30,40 on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after 40, out_sum=100, out_count=4, in_ready=0 for that cycle, then the next sample is accepted; with AVG_EN, out_avg=25.
- Full frame with out_ready=0 for 5 cycles while in_valid=1 with data 7 -> out_sum=100 held, in_ready=0 throughout, no samples absorbed; after out_ready=1 the next frame starts from 0.
- Four samples of 0xFFFF -> out_sum=0x3FFFC (18 bits), no wrap.
- Flush cases:
  - Samples 5,7, then flush alone -> out_sum=12, out_count=2.
  - Sample 1, then flush together with sample 3 -> out_sum=4, out_count=2.
  - Flush with counter=0 -> no out_valid.
- Reset mid-frame: samples 9,9, assert reset_n=0 for 1 cycle, then 1,2,3,4 -> out_sum=10, out_count=4.

Source files
------------

// File: rtl/mac_frame_accumulator.sv
// Frame accumulator behind the MAC register: sums ACC_LEN products (or a flushed
// partial frame) and holds the sum on a valid/ready output. Optional out_avg via MAC_FRAME_ACC_AVG_EN.
package params;
    localparam int DATA_OUT_WIDTH = 16;
endpackage

module mac_frame_accumulator #(
    parameter  int IN_WIDTH  = params::DATA_OUT_WIDTH,
    parameter  int ACC_LEN   = 8,
    localparam int CNT_WIDTH = $clog2(ACC_LEN + 1),
    localparam int SUM_WIDTH = IN_WIDTH + $clog2(ACC_LEN)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [SUM_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef MAC_FRAME_ACC_AVG_EN
    ,
    output logic [IN_WIDTH-1:0]  out_avg
`endif
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(ACC_LEN - 1);

    if (ACC_LEN < 2 || ACC_LEN > 256) begin : g_bad_len
        $error("mac_frame_accumulator: ACC_LEN must be in 2..256");
    end

    state_t                 state_q, state_d;
    logic [SUM_WIDTH-1:0]   acc_q, acc_d, acc_plus, sum_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc, count_d;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign acc_plus  = acc_q + {{(SUM_WIDTH-IN_WIDTH){1'b0}}, in_data};
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = out_sum;
        count_d = out_count;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (flush || cnt_q == LAST) begin
                        sum_d   = acc_plus;
                        count_d = cnt_inc;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        acc_d = acc_plus;
                        cnt_d = cnt_inc;
                    end
                end else if (flush && cnt_q != '0) begin
                    // A flush on an empty frame is dropped: never emit count 0.
                    sum_d   = acc_q;
                    count_d = cnt_q;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_sum   <= '0;
            out_count <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_sum   <= sum_d;
            out_count <= count_d;
        end
    end

`ifdef MAC_FRAME_ACC_AVG_EN
    localparam int AVG_SHIFT = $clog2(ACC_LEN);

    if ((1 << AVG_SHIFT) != ACC_LEN) begin : g_bad_avg_len
        $error("mac_frame_accumulator: ACC_LEN must be a power of two with averaging");
    end

    // Flushed frames are still divided by ACC_LEN, not by their sample count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_avg <= '0;
        else          out_avg <= sum_d[SUM_WIDTH-1:AVG_SHIFT];
    end
`endif

endmodule

// File: tb/tb_mac_frame_accumulator.sv
// Scoreboard bench for mac_frame_accumulator (ACC_LEN=4, IN_WIDTH=16): directed
// frames push expected results; a negedge monitor checks each output handshake.
module tb_mac_frame_accumulator;
    localparam int IW = 16;
    localparam int AL = 4;
    localparam int CW = 3;
    localparam int SW = 18;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic [SW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready = 1'b1;
`ifdef MAC_FRAME_ACC_AVG_EN
    logic [IW-1:0] out_avg;
`endif

    mac_frame_accumulator #(.IN_WIDTH(IW), .ACC_LEN(AL)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_sum(out_sum), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef MAC_FRAME_ACC_AVG_EN
        , .out_avg(out_avg)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] sum;
        logic [CW-1:0] cnt;
        logic [IW-1:0] avg;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endfunction

    function automatic void expect_frame(logic [SW-1:0] s, logic [CW-1:0] c, logic [IW-1:0] a);
        exp_t e;
        e.sum = s; e.cnt = c; e.avg = a;
        sb.push_back(e);
    endfunction

    // Handshake happens at the next posedge; inputs are already stable here.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got sum %0h count %0d expected none", out_sum, out_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_sum", 32'(out_sum), 32'(e.sum));
                check("frame_count", 32'(out_count), 32'(e.cnt));
`ifdef MAC_FRAME_ACC_AVG_EN
                check("frame_avg", 32'(out_avg), 32'(e.avg));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] d, input logic f);
        in_data = d; in_valid = 1'b1; flush = f;
        step();
        in_valid = 1'b0; flush = 1'b0;
    endtask

    // Frame just emitted: output visible, input blocked, then one handshake cycle.
    task automatic wait_frame(string name);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // reset state, during and right after release
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_out_valid", 32'(out_valid), 32'd0);
        check("rel_out_sum", 32'(out_sum), 32'd0);
        check("rel_out_count", 32'(out_count), 32'd0);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        step();

        // basic full frame
        expect_frame(18'd100, 3'd4, 16'd25);
        send(16'd10, 1'b0); send(16'd20, 1'b0); send(16'd30, 1'b0); send(16'd40, 1'b0);
        wait_frame("full");

        // back-pressure: output held, samples ignored
        out_ready = 1'b0;
        expect_frame(18'd100, 3'd4, 16'd25);
        send(16'd25, 1'b0); send(16'd25, 1'b0); send(16'd25, 1'b0); send(16'd25, 1'b0);
        in_valid = 1'b1; in_data = 16'd7;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_sum", 32'(out_sum), 32'd100);
            check("stall_count", 32'(out_count), 32'd4);
            step();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        step();
        expect_frame(18'd28, 3'd4, 16'd7);
        send(16'd7, 1'b0); send(16'd7, 1'b0); send(16'd7, 1'b0); send(16'd7, 1'b0);
        wait_frame("after_stall");

        // max samples, no wrap
        expect_frame(18'h3FFFC, 3'd4, 16'hFFFF);
        repeat (4) send(16'hFFFF, 1'b0);
        wait_frame("max");

        // flush alone after two samples
        expect_frame(18'd12, 3'd2, 16'd3);
        send(16'd5, 1'b0); send(16'd7, 1'b0);
        flush = 1'b1; step(); flush = 1'b0;
        wait_frame("flush_alone");

        // flush together with a sample
        expect_frame(18'd4, 3'd2, 16'd1);
        send(16'd1, 1'b0); send(16'd3, 1'b1);
        wait_frame("flush_with_sample");

        // flush on empty frame emits nothing
        flush = 1'b1; step(); flush = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("empty_flush_no_valid", 32'(out_valid), 32'd0);
            step();
        end

        // reset mid-frame discards the partial sum
        send(16'd9, 1'b0); send(16'd9, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step();
        expect_frame(18'd10, 3'd4, 16'd2);
        send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0); send(16'd4, 1'b0);
        wait_frame("post_reset");

        repeat (3) step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
